// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master basil bus arbiter.
// Holds the FSM state encoding and the master index constants.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_GAP    = 2'd3
  } arb_state_e;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/bus_arbiter_2m.sv
// Round-robin arbiter sharing one basil register bus between two masters.
// Grants whole bursts; a watchdog reclaims the bus from a master that never lets go.
module bus_arbiter_2m
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ABUSWIDTH  = 32,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 65536
) (
  input  logic                 clk,
  input  logic                 UART_RST,
  input  logic                 M0_REQ,
  input  logic                 M1_REQ,
  output logic                 M0_GNT,
  output logic                 M1_GNT,
  input  logic [ABUSWIDTH-1:0] M0_ADD,
  input  logic [ABUSWIDTH-1:0] M1_ADD,
  input  logic                 M0_WR,
  input  logic                 M1_WR,
  input  logic                 M0_RD,
  input  logic                 M1_RD,
  input  logic [7:0]           M0_DIN,
  input  logic [7:0]           M1_DIN,
  output logic [7:0]           M_DOUT,
  output logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [7:0]           BUS_DATA,
  output logic                 BUS_WR,
  output logic                 BUS_RD,
  output logic                 TIMEOUT_ERR,
  input  logic                 ERR_CLR
);

  // The counter also times the GAP state, so it must hold GAP_CYCLES (up to 15).
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CW   = (TO_W > 4) ? TO_W : 4;
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic          WDOG_ON  = (TIMEOUT != 0);

  arb_state_e          stateQ, stateD;
  logic [CW-1:0]       cntQ, cntD;
  logic                lastQ, lastD;
  logic [1:0]          lockQ, lockD;
  logic                errQ, errD;
  logic [ABUSWIDTH-1:0] addrQ, addrD;

  logic [1:0]    eligible;
  logic [1:0]    setLock;
  logic          setErr;
  logic [CW-1:0] cntInc;
  logic          timeoutHit;
  logic          gnt0, gnt1;
  logic [7:0]    busDin;

  always_ff @(posedge clk or posedge UART_RST) begin
    if (UART_RST) begin
      stateQ <= ST_IDLE;
      cntQ   <= '0;
      lastQ  <= MASTER1;
      lockQ  <= 2'b00;
      errQ   <= 1'b0;
      addrQ  <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      lastQ  <= lastD;
      lockQ  <= lockD;
      errQ   <= errD;
      addrQ  <= addrD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    cntD       = cntQ;
    lastD      = lastQ;
    setLock    = 2'b00;
    setErr     = 1'b0;
    eligible   = {M1_REQ & ~lockQ[1], M0_REQ & ~lockQ[0]};
    cntInc     = (cntQ == '1) ? cntQ : cntQ + 1'b1;
    timeoutHit = WDOG_ON && (cntQ >= TO_LAST);

    case (stateQ)
      ST_IDLE: begin
        cntD = '0;
        if (eligible == 2'b11) begin
          stateD = (lastQ == MASTER1) ? ST_GRANT0 : ST_GRANT1;
        end else if (eligible[0]) begin
          stateD = ST_GRANT0;
        end else if (eligible[1]) begin
          stateD = ST_GRANT1;
        end
      end
      // A timeout takes priority over a simultaneous REQ release.
      ST_GRANT0: begin
        cntD = cntInc;
        if (timeoutHit) begin
          stateD     = ST_GAP;
          cntD       = '0;
          setErr     = 1'b1;
          setLock[0] = 1'b1;
        end else if (!M0_REQ) begin
          stateD = ST_GAP;
          cntD   = '0;
          lastD  = MASTER0;
        end
      end
      ST_GRANT1: begin
        cntD = cntInc;
        if (timeoutHit) begin
          stateD     = ST_GAP;
          cntD       = '0;
          setErr     = 1'b1;
          setLock[1] = 1'b1;
        end else if (!M1_REQ) begin
          stateD = ST_GAP;
          cntD   = '0;
          lastD  = MASTER1;
        end
      end
      ST_GAP: begin
        if (cntQ >= GAP_LAST) begin
          stateD = ST_IDLE;
          cntD   = '0;
        end else begin
          cntD = cntInc;
        end
      end
      default: begin
        stateD = ST_IDLE;
        cntD   = '0;
      end
    endcase
  end

  // Lockout and error set both beat their clears when they coincide.
  always_comb begin
    lockD[0] = setLock[0] | (lockQ[0] & M0_REQ);
    lockD[1] = setLock[1] | (lockQ[1] & M1_REQ);
    errD     = setErr | (errQ & ~ERR_CLR);
  end

  always_comb begin
    gnt0    = (stateQ == ST_GRANT0);
    gnt1    = (stateQ == ST_GRANT1);
    BUS_WR  = (gnt0 & M0_WR) | (gnt1 & M1_WR);
    BUS_RD  = (gnt0 & M0_RD) | (gnt1 & M1_RD);
    busDin  = gnt1 ? M1_DIN : M0_DIN;
    BUS_ADD = addrQ;
    if (gnt0) begin
      BUS_ADD = M0_ADD;
    end else if (gnt1) begin
      BUS_ADD = M1_ADD;
    end
    addrD = BUS_ADD;
  end

  assign M0_GNT      = gnt0;
  assign M1_GNT      = gnt1;
  assign TIMEOUT_ERR = errQ;
  assign BUS_DATA    = BUS_WR ? busDin : 8'hzz;
  assign M_DOUT      = BUS_DATA;

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed bench for bus_arbiter_2m: a cycle-by-cycle vector table for
// arbitration and bus muxing, then hand sequences for watchdog and reset.
module tb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        UART_RST;
  logic        M0_REQ, M1_REQ;
  logic        M0_GNT, M1_GNT;
  logic [31:0] M0_ADD, M1_ADD;
  logic        M0_WR, M1_WR, M0_RD, M1_RD;
  logic [7:0]  M0_DIN, M1_DIN;
  logic [7:0]  M_DOUT;
  logic [31:0] BUS_ADD;
  wire  [7:0]  BUS_DATA;
  logic        BUS_WR, BUS_RD;
  logic        TIMEOUT_ERR;
  logic        ERR_CLR;
  logic        slvEn;
  logic [7:0]  slvData;

  int nApplied = 0;
  int nMis     = 0;

  assign BUS_DATA = slvEn ? slvData : 8'hzz;

  always #5 clk = ~clk;

  bus_arbiter_2m #(
    .ABUSWIDTH(32),
    .GAP_CYCLES(2),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .UART_RST(UART_RST),
    .M0_REQ(M0_REQ),
    .M1_REQ(M1_REQ),
    .M0_GNT(M0_GNT),
    .M1_GNT(M1_GNT),
    .M0_ADD(M0_ADD),
    .M1_ADD(M1_ADD),
    .M0_WR(M0_WR),
    .M1_WR(M1_WR),
    .M0_RD(M0_RD),
    .M1_RD(M1_RD),
    .M0_DIN(M0_DIN),
    .M1_DIN(M1_DIN),
    .M_DOUT(M_DOUT),
    .BUS_ADD(BUS_ADD),
    .BUS_DATA(BUS_DATA),
    .BUS_WR(BUS_WR),
    .BUS_RD(BUS_RD),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .ERR_CLR(ERR_CLR)
  );

  typedef struct {
    logic        r0, r1, wr0, rd0, wr1, rd1;
    logic [31:0] a0, a1;
    logic [7:0]  d0, d1;
    logic        slvEn;
    logic [7:0]  slv;
    logic        g0, g1, bw, br;
    logic [31:0] bAdd;
    logic        chkDout;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(
    input logic r0, r1, wr0, rd0, wr1, rd1,
    input logic [31:0] a0, a1,
    input logic [7:0] d0, d1,
    input logic sEn, input logic [7:0] slv,
    input logic g0, g1, bw, br,
    input logic [31:0] bAdd,
    input logic chk, input logic [7:0] dout);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.wr0 = wr0; v.rd0 = rd0; v.wr1 = wr1; v.rd1 = rd1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.slvEn = sEn; v.slv = slv;
    v.g0 = g0; v.g1 = g1; v.bw = bw; v.br = br; v.bAdd = bAdd;
    v.chkDout = chk; v.dout = dout;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    M0_REQ = v.r0; M1_REQ = v.r1;
    M0_WR = v.wr0; M0_RD = v.rd0; M1_WR = v.wr1; M1_RD = v.rd1;
    M0_ADD = v.a0; M1_ADD = v.a1; M0_DIN = v.d0; M1_DIN = v.d1;
    slvEn = v.slvEn; slvData = v.slv;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic sawGnt;

    // r0 r1 wr0 rd0 wr1 rd1  a0  a1  d0  d1  slvEn slv | g0 g1 bw br bAdd chk dout
    vecs[0]  = mk(0,0,0,0,0,0, 32'h0,    32'h0,  8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h0,    0,8'h00);
    vecs[1]  = mk(1,0,0,0,0,0, 32'h1000, 32'h0,  8'h00,8'h00, 0,8'h00, 1,0,0,0, 32'h1000, 0,8'h00);
    vecs[2]  = mk(1,0,1,0,1,0, 32'h1000, 32'h0,  8'h5A,8'hFF, 0,8'h00, 1,0,1,0, 32'h1000, 1,8'h5A);
    vecs[3]  = mk(1,0,0,0,1,1, 32'h1000, 32'h0,  8'h00,8'hFF, 1,8'h3C, 1,0,0,0, 32'h1000, 1,8'h3C);
    vecs[4]  = mk(0,0,0,0,0,0, 32'h1000, 32'h0,  8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h1000, 0,8'h00);
    vecs[5]  = mk(1,1,0,0,0,0, 32'h2222, 32'h40, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h1000, 0,8'h00);
    vecs[6]  = mk(1,1,0,0,0,0, 32'h2222, 32'h40, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h1000, 0,8'h00);
    vecs[7]  = mk(1,1,0,0,0,0, 32'h2222, 32'h40, 8'h00,8'h00, 0,8'h00, 0,1,0,0, 32'h40,   0,8'h00);
    vecs[8]  = mk(1,1,1,1,0,1, 32'h3333, 32'h40, 8'hAA,8'h00, 0,8'h00, 0,1,0,1, 32'h40,   0,8'h00);
    vecs[9]  = mk(1,0,0,0,0,0, 32'h3333, 32'h40, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h40,   0,8'h00);
    vecs[10] = mk(1,1,0,0,0,0, 32'h1000, 32'h40, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h40,   0,8'h00);
    vecs[11] = mk(1,1,0,0,0,0, 32'h1000, 32'h40, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h40,   0,8'h00);
    vecs[12] = mk(1,1,0,0,0,0, 32'h1000, 32'h40, 8'h00,8'h00, 0,8'h00, 1,0,0,0, 32'h1000, 0,8'h00);
    vecs[13] = mk(0,1,0,0,0,0, 32'h1000, 32'h40, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h1000, 0,8'h00);
    vecs[14] = mk(0,1,0,0,0,0, 32'h1000, 32'h40, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h1000, 0,8'h00);
    vecs[15] = mk(0,1,0,0,0,0, 32'h1000, 32'h40, 8'h00,8'h00, 0,8'h00, 0,0,0,0, 32'h1000, 0,8'h00);
    vecs[16] = mk(0,1,0,0,0,0, 32'h1000, 32'h40, 8'h00,8'h00, 0,8'h00, 0,1,0,0, 32'h40,   0,8'h00);

    UART_RST = 1'b1;
    ERR_CLR  = 1'b0;
    applyStimulus(vecs[0]);
    #1;
    checkOutput("reset_state", {M0_GNT, M1_GNT, BUS_WR, BUS_RD, TIMEOUT_ERR, BUS_ADD},
                {5'b00000, 32'h0});
    repeat (2) @(posedge clk);
    #3 UART_RST = 1'b0;

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d", i),
                  {M0_GNT, M1_GNT, BUS_WR, BUS_RD, TIMEOUT_ERR, BUS_ADD},
                  {vecs[i].g0, vecs[i].g1, vecs[i].bw, vecs[i].br, 1'b0, vecs[i].bAdd});
      if (vecs[i].chkDout) begin
        checkOutput($sformatf("vec%0d_dout", i), M_DOUT, vecs[i].dout);
      end
    end

    // M1 keeps REQ high: watchdog must end the grant after 16 cycles.
    cyc = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!M1_GNT) break;
      cyc++;
    end
    checkOutput("wdog_m1_cycles", cyc, 16);
    checkOutput("wdog_m1_err", TIMEOUT_ERR, 1);

    sawGnt = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (M1_GNT) sawGnt = 1'b1;
    end
    checkOutput("lockout_hold", sawGnt, 0);

    M1_REQ = 1'b0;
    step();
    M1_REQ = 1'b1;
    step();
    checkOutput("regrant_after_low", {M0_GNT, M1_GNT}, 2'b01);
    checkOutput("err_sticky", TIMEOUT_ERR, 1);

    M1_REQ = 1'b0;
    repeat (3) step();

    // Reset in the middle of an M0 read burst.
    M0_REQ = 1'b1;
    M0_ADD = 32'h0800;
    step();
    checkOutput("m0_read_gnt", M0_GNT, 1);
    M0_RD = 1'b1;
    #1;
    checkOutput("m0_read_strobe", {BUS_RD, BUS_ADD}, {1'b1, 32'h0800});
    UART_RST = 1'b1;
    #1;
    checkOutput("reset_mid_read", {M0_GNT, BUS_RD, TIMEOUT_ERR, BUS_ADD}, {3'b000, 32'h0});
    M0_REQ = 1'b0;
    M0_RD  = 1'b0;
    @(posedge clk);
    #3 UART_RST = 1'b0;

    M0_REQ = 1'b1;
    M1_REQ = 1'b1;
    step();
    checkOutput("tie_after_reset", {M0_GNT, M1_GNT}, 2'b10);

    // ERR_CLR held across the timeout edge: the set must still win.
    ERR_CLR = 1'b1;
    cyc = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!M0_GNT) break;
      cyc++;
    end
    checkOutput("wdog_m0_cycles", cyc, 16);
    checkOutput("err_set_beats_clr", TIMEOUT_ERR, 1);
    step();
    checkOutput("err_clr", TIMEOUT_ERR, 0);
    ERR_CLR = 1'b0;
    step();
    step();
    checkOutput("m1_after_m0_timeout", {M0_GNT, M1_GNT}, 2'b01);

    M0_REQ = 1'b0;
    M1_REQ = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMis);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2m.md
# bus_arbiter_2m

Two-master, round-robin arbiter for the 8-bit basil register bus (32-bit address, bidirectional 8-bit data, WR/RD strobes). It lets `uart_master` and a second bus master, such as a host/USB bridge, share one slave bus. Each master owns the bus for a full burst between REQ rise and REQ fall. A per-grant watchdog forcibly reclaims the bus from a master that never releases it.

## Interface
Parameters:
- ABUSWIDTH, 32: address width of masters and bus.
- GAP_CYCLES, 2: idle cycles inserted after every grant release (1..15).
- TIMEOUT, 65536: maximum granted cycles before forced release; 0 disables the watchdog.

Ports:
- clk  in  1  bus clock.
- UART_RST  in  1  reset; asynchronous, active-high.
- M0_REQ, M1_REQ  in  1  bus request; master holds high for whole burst.
- M0_GNT, M1_GNT  out  1  registered grant.
- M0_ADD, M1_ADD  in  ABUSWIDTH  master address.
- M0_WR, M1_WR, M0_RD, M1_RD  in  1  master strobes.
- M0_DIN, M1_DIN  in  8  master write data.
- M_DOUT  out  8  read data (BUS_DATA), broadcast to both masters.
- BUS_ADD  out  ABUSWIDTH  slave address.
- BUS_DATA  inout  8  slave data.
- BUS_WR, BUS_RD  out  1  slave strobes.
- TIMEOUT_ERR  out  1  sticky watchdog flag.
- ERR_CLR  in  1  synchronous clear of TIMEOUT_ERR.

## Operation
States:
- IDLE: no grant.
  - Exactly one eligible REQ high: go to GRANT of that master.
  - Both eligible REQs high: grant the master not served last.
  - The "last served" pointer resets to 1, so master 0 wins the first tie.
- GRANT0 / GRANT1: GNT of that master high.
  - Its REQ low at a clock edge: go to GAP. The pointer is updated to this master.
  - Watchdog counter reaches TIMEOUT: go to GAP, set TIMEOUT_ERR, set this master's lockout bit.
- GAP: counts GAP_CYCLES, then goes to IDLE. REQs are ignored during GAP.

Eligibility and lockout:
- A master is eligible when REQ is high and its lockout bit is clear.
- A lockout bit clears on the first edge at which that master's REQ is seen low.

Bus mux (combinational from state):
- BUS_ADD, BUS_WR and BUS_RD follow the granted master's signals.
- Outside GRANT states: BUS_WR = BUS_RD = 0 and BUS_ADD holds its last value.
- The non-granted master's strobes never reach the bus.

Data path:
- BUS_DATA is driven with the granted master's DIN only while BUS_WR = 1; otherwise it is high-Z.
- M_DOUT = BUS_DATA at all times.

Watchdog counter:
- Cleared on entry to a GRANT state, then increments each granted cycle.
- Width ≥ clog2(TIMEOUT+1), with saturating arithmetic.

TIMEOUT_ERR:
- Set wins over ERR_CLR when both occur in the same cycle.

Reset values: M0_GNT = M1_GNT = 0, BUS_WR = BUS_RD = 0, BUS_ADD = 0, BUS_DATA = Z, TIMEOUT_ERR = 0, lockouts = 0, state IDLE.

Reset mid-burst: the grant drops and the strobes go to 0 immediately (asynchronously). No bus cycle completes.

## Timing
- Grant latency:
  - REQ sampled high at edge k in IDLE gives GNT high after edge k+1.
  - Masters must not drive strobes before GNT is seen high.
- Release:
  - REQ sampled low at edge k gives GNT low after edge k+1.
  - The next grant is earliest after edge k+1+GAP_CYCLES+1.
- Strobe path is combinational: master strobe to BUS_WR/BUS_RD in 0 cycles. Slave read data is valid per the existing bus read timing.
- REQ deassertion and a timeout in the same cycle: treated as a timeout (flag set, lockout set; the lockout clears next edge because REQ is low).
- Both REQs rising in the same cycle as a release: REQs are ignored during GAP; arbitration happens in IDLE using the updated pointer.

## Structure
- Shared package `bus_arbiter_pkg`:
  - State encoding (IDLE, GRANT0, GRANT1, GAP).
  - Master index constants.
- Single flat module, no sub-module. The watchdog and GAP counter are one shared counter register.

## Test plan
- Single master: M0_REQ held high, one write of 0x5A to address 0x1000, then REQ low. Required: GNT0 high 1 cycle after REQ; BUS_WR/BUS_ADD/BUS_DATA mirror M0; GNT0 low 1 cycle after REQ low; bus idle for GAP_CYCLES.
- Simultaneous REQ after reset: M0 is served first. At M0 release M1 is still requesting, so GNT1 follows after the gap. Repeat with both high: M0 is granted again (fair alternation).
- Isolation: M1 toggles WR/RD and drives DIN = 0xFF while M0 is granted. Required: BUS_WR/BUS_RD/BUS_DATA carry only M0 values; BUS_DATA is Z when M0_WR = 0.
- Watchdog, TIMEOUT=16: M1 holds REQ. Required: GNT1 drops after 16 granted cycles, TIMEOUT_ERR = 1, M1 not regranted until its REQ goes low; ERR_CLR clears the flag.
- Reset mid-read: assert UART_RST during an M0 burst. Required: GNT0, BUS_RD and TIMEOUT_ERR are 0 immediately; after release, the first tie goes to M0.
